micro_cmd_iface: RTL and testbench

MICRO_CMD_IFACE -- requirements
Module: micro_cmd_iface

---
 rtl/micro_cmd_iface.sv | 215 +++++++++++++++++++++
 tb/tb_micro_cmd_iface.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/micro_cmd_iface.sv
// Processor GPIO command decoder driving the image address FSM, the pixel write port and result readback.
// A command executes only when its toggle bit differs from the last accepted toggle.
module micro_cmd_iface #(
  parameter int NB_GPIO  = 32,
  parameter int NB_DATA  = 8,
  parameter int NB_IMAGE = 10,
  parameter int RD_LAT   = 2
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic [NB_GPIO-1:0]  i_GPIO_data,
  input  logic                i_EoP,
  input  logic [NB_DATA-1:0]  i_rdata,
  output logic [NB_GPIO-1:0]  o_GPIO_data,
  output logic [NB_IMAGE-1:0] o_imgLength,
  output logic                o_load,
  output logic                o_SoP,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_wdata,
  output logic                o_softReset
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_PROC = 2'b10,
    ST_READ = 2'b11
  } state_t;

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_SET_LEN  = 3'b001;
  localparam logic [2:0] OP_LD_START = 3'b010;
  localparam logic [2:0] OP_DATA     = 3'b011;
  localparam logic [2:0] OP_LD_END   = 3'b100;
  localparam logic [2:0] OP_SOP      = 3'b101;
  localparam logic [2:0] OP_READ     = 3'b110;
  localparam logic [2:0] OP_SOFT_RST = 3'b111;

  logic [3+NB_DATA:0]  cmd_r;
  logic                eop_r;
  logic                toggle_r;
  state_t              state_r;
  logic                load_r;
  logic                sop_r;
  logic                valid_r;
  logic [NB_DATA-1:0]  wdata_r;
  logic [NB_IMAGE-1:0] img_len_r;
  logic                err_r;
  logic                srst_r;
  logic [NB_DATA-1:0]  rdata_r;
  logic [RD_LAT-1:0]   rd_pipe_r;
  logic [NB_GPIO-1:0]  status_r;

  logic [2:0]          cmd_op_s;
  logic                cmd_tog_s;
  logic [NB_DATA-1:0]  cmd_payload_s;
  logic                accept_s;
  logic                rd_busy_s;
  logic                gpio_unused_s;

  state_t              state_nxt_s;
  logic                toggle_nxt_s;
  logic                load_nxt_s;
  logic                sop_nxt_s;
  logic                valid_nxt_s;
  logic [NB_DATA-1:0]  wdata_nxt_s;
  logic [NB_IMAGE-1:0] img_len_nxt_s;
  logic                err_nxt_s;
  logic                srst_nxt_s;
  logic                rd_req_s;
  logic                rd_flush_s;

  assign gpio_unused_s = ^i_GPIO_data[NB_GPIO-5:NB_DATA];
  assign cmd_op_s      = cmd_r[3+NB_DATA -: 3];
  assign cmd_tog_s     = cmd_r[NB_DATA];
  assign cmd_payload_s = cmd_r[NB_DATA-1:0];
  assign rd_busy_s     = |rd_pipe_r;
  // A new command waits one cycle after a strobe so o_valid can never stay high twice in a row.
  assign accept_s      = (cmd_tog_s != toggle_r) && !valid_r;

  // Next-state and next-output decode for the command FSM.
  always_comb begin
    state_nxt_s   = state_r;
    toggle_nxt_s  = toggle_r;
    load_nxt_s    = load_r;
    sop_nxt_s     = sop_r;
    valid_nxt_s   = 1'b0;
    wdata_nxt_s   = wdata_r;
    img_len_nxt_s = img_len_r;
    err_nxt_s     = err_r;
    srst_nxt_s    = 1'b0;
    rd_req_s      = 1'b0;
    rd_flush_s    = 1'b0;

    if ((state_r == ST_PROC) && eop_r) begin
      state_nxt_s = ST_READ;
      sop_nxt_s   = 1'b0;
    end else begin
      sop_nxt_s   = sop_r;
    end

    if (accept_s) begin
      toggle_nxt_s = cmd_tog_s;
      case (cmd_op_s)
        OP_NOP: begin
          err_nxt_s = err_r;
        end
        OP_SET_LEN: begin
          if (state_r == ST_IDLE) img_len_nxt_s = NB_IMAGE'(cmd_payload_s);
          else                    err_nxt_s = 1'b1;
        end
        OP_LD_START: begin
          if ((state_r == ST_IDLE) || (state_r == ST_READ)) begin
            state_nxt_s = ST_LOAD;
            load_nxt_s  = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        OP_DATA: begin
          if (state_r == ST_LOAD) begin
            wdata_nxt_s = cmd_payload_s;
            valid_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        OP_LD_END: begin
          if (state_r == ST_LOAD) begin
            state_nxt_s = ST_IDLE;
            load_nxt_s  = 1'b0;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        OP_SOP: begin
          if (state_r == ST_IDLE) begin
            state_nxt_s = ST_PROC;
            sop_nxt_s   = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        OP_READ: begin
          if ((state_r == ST_READ) && !rd_busy_s) begin
            valid_nxt_s = 1'b1;
            rd_req_s    = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        OP_SOFT_RST: begin
          state_nxt_s = ST_IDLE;
          load_nxt_s  = 1'b0;
          sop_nxt_s   = 1'b0;
          valid_nxt_s = 1'b0;
          err_nxt_s   = 1'b0;
          srst_nxt_s  = 1'b1;
          rd_flush_s  = 1'b1;
        end
        default: begin
          err_nxt_s = 1'b1;
        end
      endcase
    end else begin
      toggle_nxt_s = toggle_r;
    end
  end

  // State, output and readback registers; the read pipe marks when i_rdata is due.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      cmd_r     <= '0;
      eop_r     <= 1'b0;
      toggle_r  <= 1'b0;
      state_r   <= ST_IDLE;
      load_r    <= 1'b0;
      sop_r     <= 1'b0;
      valid_r   <= 1'b0;
      wdata_r   <= '0;
      img_len_r <= '0;
      err_r     <= 1'b0;
      srst_r    <= 1'b0;
      rdata_r   <= '0;
      rd_pipe_r <= '0;
      status_r  <= '0;
    end else begin
      cmd_r     <= {i_GPIO_data[NB_GPIO-1 -: 4], i_GPIO_data[NB_DATA-1:0]};
      eop_r     <= i_EoP;
      toggle_r  <= toggle_nxt_s;
      state_r   <= state_nxt_s;
      load_r    <= load_nxt_s;
      sop_r     <= sop_nxt_s;
      valid_r   <= valid_nxt_s;
      wdata_r   <= wdata_nxt_s;
      img_len_r <= img_len_nxt_s;
      err_r     <= err_nxt_s;
      srst_r    <= srst_nxt_s;
      if (rd_pipe_r[RD_LAT-1]) rdata_r <= i_rdata;
      else                     rdata_r <= rdata_r;
      if (rd_flush_s) rd_pipe_r <= '0;
      else            rd_pipe_r <= (rd_pipe_r << 1'b1) | RD_LAT'(rd_req_s);
      status_r  <= {state_r, eop_r, err_r, {(NB_GPIO-4-NB_DATA){1'b0}}, rdata_r};
    end
  end

  assign o_GPIO_data = status_r;
  assign o_imgLength = img_len_r;
  assign o_load      = load_r;
  assign o_SoP       = sop_r;
  assign o_valid     = valid_r;
  assign o_wdata     = wdata_r;
  assign o_softReset = srst_r;

endmodule

// File: tb/tb_micro_cmd_iface.sv
// Directed bench for micro_cmd_iface: walks length set, load, process, readback, soft and hard reset.
module tb_micro_cmd_iface;

  logic        i_CLK;
  logic        i_reset;
  logic [31:0] i_GPIO_data;
  logic        i_EoP;
  logic [7:0]  i_rdata;
  logic [31:0] o_GPIO_data;
  logic [9:0]  o_imgLength;
  logic        o_load;
  logic        o_SoP;
  logic        o_valid;
  logic [7:0]  o_wdata;
  logic        o_softReset;

  int   n_cmp;
  int   n_err;
  logic tog;

  micro_cmd_iface dut (
    .i_CLK       (i_CLK),
    .i_reset     (i_reset),
    .i_GPIO_data (i_GPIO_data),
    .i_EoP       (i_EoP),
    .i_rdata     (i_rdata),
    .o_GPIO_data (o_GPIO_data),
    .o_imgLength (o_imgLength),
    .o_load      (o_load),
    .o_SoP       (o_SoP),
    .o_valid     (o_valid),
    .o_wdata     (o_wdata),
    .o_softReset (o_softReset)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flip the toggle, present the command, and return just after the edge that executes it.
  task automatic send(input logic [2:0] op, input logic [7:0] pl);
    tog = ~tog;
    i_GPIO_data = {op, tog, 20'h00000, pl};
    tick();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tog = 1'b0;
    i_CLK = 1'b0;
    i_reset = 1'b0;
    i_GPIO_data = 32'h0;
    i_EoP = 1'b0;
    i_rdata = 8'h5A;
    tick();
    tick();
    chk("rst_status", o_GPIO_data, 32'h0);
    chk("rst_len", {22'h0, o_imgLength}, 32'h0);
    chk("rst_ctrl", {28'h0, o_load, o_SoP, o_valid, o_softReset}, 32'h0);
    chk("rst_wdata", {24'h0, o_wdata}, 32'h0);
    i_reset = 1'b1;
    tick();

    // First command with toggle 0 must be ignored
    i_GPIO_data = {3'b001, 1'b0, 20'h00000, 8'h55};
    tick();
    tick();
    chk("tog0_ignored", {22'h0, o_imgLength}, 32'h0);
    send(3'b001, 8'h40);
    chk("set_len", {22'h0, o_imgLength}, 32'd64);
    tick();
    chk("idle_status", o_GPIO_data, 32'h0);

    send(3'b010, 8'h00);
    chk("load_start", {31'h0, o_load}, 32'h1);
    tick();
    chk("load_status", o_GPIO_data, 32'h40000000);
    send(3'b011, 8'h11);
    chk("data11_valid", {31'h0, o_valid}, 32'h1);
    chk("data11_wdata", {24'h0, o_wdata}, 32'h11);
    tick();
    chk("data11_pulse", {31'h0, o_valid}, 32'h0);
    send(3'b011, 8'h22);
    chk("data22_valid", {31'h0, o_valid}, 32'h1);
    chk("data22_wdata", {24'h0, o_wdata}, 32'h22);
    tick();
    chk("data22_pulse", {31'h0, o_valid}, 32'h0);
    // Back-to-back toggles: second DATA must be spaced out by one idle cycle
    tog = ~tog;
    i_GPIO_data = {3'b011, tog, 20'h00000, 8'h33};
    tick();
    tog = ~tog;
    i_GPIO_data = {3'b011, tog, 20'h00000, 8'h44};
    tick();
    chk("data33_valid", {31'h0, o_valid}, 32'h1);
    chk("data33_wdata", {24'h0, o_wdata}, 32'h33);
    tick();
    chk("b2b_gap", {31'h0, o_valid}, 32'h0);
    tick();
    chk("data44_valid", {31'h0, o_valid}, 32'h1);
    chk("data44_wdata", {24'h0, o_wdata}, 32'h44);
    chk("load_held", {31'h0, o_load}, 32'h1);
    tick();
    chk("data44_pulse", {31'h0, o_valid}, 32'h0);
    send(3'b100, 8'h00);
    chk("load_end", {31'h0, o_load}, 32'h0);
    tick();
    chk("load_end_status", o_GPIO_data, 32'h0);

    send(3'b101, 8'h00);
    chk("sop_set", {31'h0, o_SoP}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sop_hold", {31'h0, o_SoP}, 32'h1);
    end
    i_EoP = 1'b1;
    tick();
    chk("sop_eop_reg", {31'h0, o_SoP}, 32'h1);
    tick();
    chk("sop_drop", {31'h0, o_SoP}, 32'h0);
    i_EoP = 1'b0;
    tick();
    chk("read_status", o_GPIO_data, 32'hE0000000);

    // i_rdata is only correct on the edge RD_LAT cycles after the pulse
    send(3'b110, 8'h00);
    chk("read_valid", {31'h0, o_valid}, 32'h1);
    tick();
    chk("read_pulse", {31'h0, o_valid}, 32'h0);
    i_rdata = 8'hA5;
    tick();
    i_rdata = 8'h5A;
    tick();
    chk("read_capture", o_GPIO_data, 32'hC00000A5);
    send(3'b011, 8'h77);
    chk("data_in_read_valid", {31'h0, o_valid}, 32'h0);
    chk("data_in_read_wdata", {24'h0, o_wdata}, 32'h44);
    tick();
    chk("data_in_read_err", o_GPIO_data, 32'hD00000A5);

    i_GPIO_data = {3'b110, tog, 20'h00000, 8'h00};
    tick();
    tick();
    chk("same_tog_read", {31'h0, o_valid}, 32'h0);
    tick();
    chk("same_tog_read2", {31'h0, o_valid}, 32'h0);
    i_GPIO_data = {3'b010, tog, 20'h00000, 8'h00};
    tick();
    tick();
    chk("same_tog_load", {31'h0, o_load}, 32'h0);

    send(3'b111, 8'h00);
    chk("srst_pulse", {31'h0, o_softReset}, 32'h1);
    tick();
    chk("srst_pulse_end", {31'h0, o_softReset}, 32'h0);
    chk("srst_status", o_GPIO_data, 32'h000000A5);
    chk("srst_len_kept", {22'h0, o_imgLength}, 32'd64);

    send(3'b101, 8'h00);
    chk("sop2_set", {31'h0, o_SoP}, 32'h1);
    send(3'b010, 8'h00);
    chk("proc_ld_ignored", {31'h0, o_load}, 32'h0);
    tick();
    chk("proc_err", o_GPIO_data, 32'h900000A5);
    chk("proc_sop_kept", {31'h0, o_SoP}, 32'h1);
    send(3'b111, 8'h00);
    chk("proc_srst", {30'h0, o_softReset, o_SoP}, 32'h2);
    tick();
    chk("proc_srst_status", o_GPIO_data, 32'h000000A5);

    // Hard reset mid-PROC must clear outputs without waiting for a clock edge
    send(3'b101, 8'h00);
    chk("sop3_set", {31'h0, o_SoP}, 32'h1);
    i_GPIO_data = 32'h0;
    #2;
    i_reset = 1'b0;
    #1;
    chk("async_sop", {31'h0, o_SoP}, 32'h0);
    chk("async_len", {22'h0, o_imgLength}, 32'h0);
    chk("async_status", o_GPIO_data, 32'h0);
    tick();
    i_reset = 1'b1;
    tog = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_ctrl", {28'h0, o_load, o_SoP, o_valid, o_softReset}, 32'h0);
    chk("post_rst_status", o_GPIO_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
